imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate and target generator for the MIPS datapath; successor to the single-mode 16→32 sign extender.
- Takes a 32-bit instruction word, PC+4 and an extension mode. Produces the extended immediate plus the branch/jump target.
- Two register stages with valid/ready backpressure, so it drops into the pipelined core between decode and execute.

---
 rtl/imm_gen_pkg.sv | 24 ++
 rtl/pipe_stage_reg.sv | 32 +++
 rtl/imm_gen_pipe.sv | 138 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared constants for the pipelined immediate / target generator.
package imm_gen_pkg;

   // Extension mode encoding carried on in_mode; 6 and 7 are illegal.
   localparam logic [2:0] MODE_SEXT   = 3'd0;
   localparam logic [2:0] MODE_ZEXT   = 3'd1;
   localparam logic [2:0] MODE_LUI    = 3'd2;
   localparam logic [2:0] MODE_BRANCH = 3'd3;
   localparam logic [2:0] MODE_JUMP   = 3'd4;
   localparam logic [2:0] MODE_SHAMT  = 3'd5;

   localparam int MODE_W    = 3;
   localparam int INSTR_W   = 32;

   // Field positions and shift amounts of the MIPS encodings.
   localparam int LUI_SHIFT = 16;
   localparam int BR_SHIFT  = 2;
   localparam int SHAMT_LSB = 6;
   localparam int SHAMT_MSB = 10;

   // Jump targets keep the PC region bits from this position upward.
   localparam int JMP_REGION_LSB = 28;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready register slice. Accepts a new beat when empty or when
// the held beat leaves in the same cycle, giving full throughput.
module pipe_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   // Ready whenever the slot is free now or frees this cycle.
   assign in_ready = !out_valid || out_ready;

   // Load on a transfer in, clear valid when the beat leaves with no refill.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate and branch/jump target generator with valid/ready
// backpressure. Stage 1 extends the immediate; stage 2 forms the target.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int JMP_W  = 26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_pc4,
   input  logic [2:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_imm,
   output logic [DATA_W-1:0] out_target,
   output logic              out_illegal,
   output logic              out_wrap
);

   typedef struct packed {
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc4;
      logic [MODE_W-1:0] mode;
      logic              illegal;
   } s1_t;

   typedef struct packed {
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] target;
      logic              illegal;
      logic              wrap;
   } s2_t;

   s1_t data_p0, data_p1;
   s2_t data_p1_res, data_p2;
   logic vld_p1, vld_p2;
   logic rdy_p1, rdy_p2;

   logic signed [DATA_W-1:0] sext_imm;
   logic        [DATA_W-1:0] zext_imm;
   logic        [DATA_W-1:0] zext_jmp;
   logic        [DATA_W-1:0] zext_shamt;
   logic        [DATA_W:0]   br_sum;
   logic                     unused_instr_bits;

   // Instruction bits above the jump field never feed any mode.
   assign unused_instr_bits = ^in_instr[31:JMP_W];

   // Field extensions feeding stage 1.
   always_comb begin
      sext_imm   = {{(DATA_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
      zext_imm   = {{(DATA_W-IMM_W){1'b0}}, in_instr[IMM_W-1:0]};
      zext_jmp   = {{(DATA_W-JMP_W){1'b0}}, in_instr[JMP_W-1:0]};
      zext_shamt = {{(DATA_W-(SHAMT_MSB-SHAMT_LSB+1)){1'b0}},
                    in_instr[SHAMT_MSB:SHAMT_LSB]};
   end

   // Select the stage 1 immediate by mode; unknown modes flag illegal.
   always_comb begin
      data_p0.pc4     = in_pc4;
      data_p0.mode    = in_mode;
      data_p0.imm     = '0;
      data_p0.illegal = 1'b0;
      case (in_mode)
         MODE_SEXT:   data_p0.imm = sext_imm;
         MODE_ZEXT:   data_p0.imm = zext_imm;
         MODE_LUI:    data_p0.imm = zext_imm << LUI_SHIFT;
         MODE_BRANCH: data_p0.imm = sext_imm << BR_SHIFT;
         MODE_JUMP:   data_p0.imm = zext_jmp << BR_SHIFT;
         MODE_SHAMT:  data_p0.imm = zext_shamt;
         default:     data_p0.illegal = 1'b1;
      endcase
   end

   // ---- stage 1 register: extended immediate, mode, pc4, illegal ----
   pipe_stage_reg #(.W($bits(s1_t))) u_stage1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (data_p0),
      .out_valid (vld_p1),
      .out_ready (rdy_p2),
      .out_data  (data_p1)
   );

   // Branch adder with one extra bit so the carry out is visible.
   assign br_sum = {1'b0, data_p1.pc4} + {1'b0, data_p1.imm};

   // Target and wrap from the stage 1 payload. A negative offset must borrow
   // (carry out) to stay in range; a positive one must not carry.
   always_comb begin
      data_p1_res.imm     = data_p1.imm;
      data_p1_res.illegal = data_p1.illegal;
      data_p1_res.target  = '0;
      data_p1_res.wrap    = 1'b0;
      case (data_p1.mode)
         MODE_BRANCH: begin
            data_p1_res.target = br_sum[DATA_W-1:0];
            data_p1_res.wrap   = data_p1.imm[DATA_W-1] ? !br_sum[DATA_W]
                                                       :  br_sum[DATA_W];
         end
         MODE_JUMP: begin
            data_p1_res.target = {data_p1.pc4[DATA_W-1:JMP_REGION_LSB],
                                  data_p1.imm[JMP_REGION_LSB-1:0]};
         end
         default: ;
      endcase
   end

   // ---- stage 2 register: immediate, target, illegal, wrap ----
   pipe_stage_reg #(.W($bits(s2_t))) u_stage2 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (vld_p1),
      .in_ready  (rdy_p2),
      .in_data   (data_p1_res),
      .out_valid (vld_p2),
      .out_ready (out_ready),
      .out_data  (data_p2)
   );

   assign rdy_p1      = rdy_p2;
   assign out_valid   = vld_p2;
   assign out_imm     = data_p2.imm;
   assign out_target  = data_p2.target;
   assign out_illegal = data_p2.illegal;
   assign out_wrap    = data_p2.wrap;

   logic unused_rdy_p1;
   assign unused_rdy_p1 = rdy_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: vector table plus backpressure and
// asynchronous reset sequences.
module tb_imm_gen_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc4;
   logic [2:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [31:0] out_target;
   logic        out_illegal;
   logic        out_wrap;

   int checks = 0;
   int errors = 0;

   imm_gen_pipe #(.DATA_W(32), .IMM_W(16), .JMP_W(26)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc4      (in_pc4),
      .in_mode     (in_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm     (out_imm),
      .out_target  (out_target),
      .out_illegal (out_illegal),
      .out_wrap    (out_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  mode;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [31:0] imm;
      logic [31:0] tgt;
      logic        ill;
      logic        wrap;
   } vec_t;

   vec_t vecs[11];
   logic [31:0] bp_instr[4];
   logic [31:0] bp_exp[4];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent;
      int got;
      logic acc;
      logic [31:0] hold_imm;

      vecs[0]  = '{3'd0, 32'h0000_8004, 32'h0000_1000, 32'hFFFF_8004, 32'h0, 1'b0, 1'b0};
      vecs[1]  = '{3'd0, 32'h0000_7FFF, 32'h0000_1000, 32'h0000_7FFF, 32'h0, 1'b0, 1'b0};
      vecs[2]  = '{3'd1, 32'h0000_8004, 32'h0000_0000, 32'h0000_8004, 32'h0, 1'b0, 1'b0};
      vecs[3]  = '{3'd2, 32'h3C01_1234, 32'h0000_0000, 32'h1234_0000, 32'h0, 1'b0, 1'b0};
      vecs[4]  = '{3'd5, 32'h0000_0140, 32'h0000_0000, 32'h0000_0005, 32'h0, 1'b0, 1'b0};
      vecs[5]  = '{3'd3, 32'h0000_FFFF, 32'h0040_0010, 32'hFFFF_FFFC, 32'h0040_000C, 1'b0, 1'b0};
      vecs[6]  = '{3'd3, 32'h0000_0001, 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1};
      vecs[7]  = '{3'd4, 32'h0810_0004, 32'hA000_0000, 32'h0040_0010, 32'hA040_0010, 1'b0, 1'b0};
      vecs[8]  = '{3'd7, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 1'b0};
      vecs[9]  = '{3'd6, 32'h0000_1234, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 1'b0};
      vecs[10] = '{3'd3, 32'h0000_8000, 32'h0000_0000, 32'hFFFE_0000, 32'hFFFE_0000, 1'b0, 1'b1};

      for (int k = 0; k < 4; k++) begin
         bp_instr[k] = 32'h0000_0100 * (k + 1) + k;
         bp_exp[k]   = bp_instr[k];
      end

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc4    = '0;
      in_mode   = 3'd0;
      out_ready = 1'b1;
      #1;
      check("rst out_valid",   out_valid,   0);
      check("rst out_imm",     out_imm,     0);
      check("rst out_target",  out_target,  0);
      check("rst out_illegal", out_illegal, 0);
      check("rst out_wrap",    out_wrap,    0);
      step();
      step();
      reset = 1'b0;
      #1;
      check("rst in_ready", in_ready, 1);

      // Table: one beat per vector with the consumer always ready.
      for (int i = 0; i < 11; i++) begin
         in_mode  = vecs[i].mode;
         in_instr = vecs[i].instr;
         in_pc4   = vecs[i].pc4;
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         check($sformatf("v%0d valid after 1 cycle", i), out_valid, 0);
         step();
         check($sformatf("v%0d valid", i),   out_valid,   1);
         check($sformatf("v%0d imm", i),     out_imm,     vecs[i].imm);
         check($sformatf("v%0d target", i),  out_target,  vecs[i].tgt);
         check($sformatf("v%0d illegal", i), out_illegal, vecs[i].ill);
         check($sformatf("v%0d wrap", i),    out_wrap,    vecs[i].wrap);
      end
      step();
      check("drained valid", out_valid, 0);

      // Backpressure: consumer stalled, only two beats fit.
      out_ready = 1'b0;
      in_mode   = 3'd0;
      in_pc4    = 32'h0;
      sent      = 0;
      for (int c = 0; c < 6; c++) begin
         if (sent < 4) begin
            in_valid = 1'b1;
            in_instr = bp_instr[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_valid && in_ready;
         step();
         if (acc) sent++;
         if (c >= 2) begin
            check($sformatf("bp stall imm c%0d", c), out_imm, bp_exp[0]);
            check($sformatf("bp stall valid c%0d", c), out_valid, 1);
         end
      end
      check("bp accepted count", sent, 2);
      check("bp in_ready low", in_ready, 0);
      hold_imm = out_imm;
      check("bp hold imm", hold_imm, bp_exp[0]);

      // Release: remaining beats stream in while results stream out.
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 12; c++) begin
         if (sent < 4) begin
            in_valid = 1'b1;
            in_instr = bp_instr[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid) begin
            if (got < 4)
               check($sformatf("bp out %0d", got), out_imm, bp_exp[got]);
            got++;
         end
         acc = in_valid && in_ready;
         step();
         if (acc) sent++;
      end
      in_valid = 1'b0;
      check("bp sent total", sent, 4);
      check("bp received total", got, 4);

      // Asynchronous reset with two beats in flight.
      in_mode  = vecs[5].mode;
      in_instr = vecs[5].instr;
      in_pc4   = vecs[5].pc4;
      in_valid = 1'b1;
      step();
      in_instr = vecs[6].instr;
      in_pc4   = vecs[6].pc4;
      step();
      in_valid = 1'b0;
      check("pre-reset valid", out_valid, 1);
      check("pre-reset target", out_target, vecs[5].tgt);
      #2;
      reset = 1'b1;
      #1;
      check("async rst valid",   out_valid,   0);
      check("async rst imm",     out_imm,     0);
      check("async rst target",  out_target,  0);
      check("async rst illegal", out_illegal, 0);
      check("async rst wrap",    out_wrap,    0);
      step();
      reset = 1'b0;
      step();
      check("no replay c1", out_valid, 0);
      step();
      check("no replay c2", out_valid, 0);

      in_mode  = vecs[0].mode;
      in_instr = vecs[0].instr;
      in_pc4   = vecs[0].pc4;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("post-rst valid 1 cycle", out_valid, 0);
      step();
      check("post-rst valid 2 cycles", out_valid, 1);
      check("post-rst imm", out_imm, vecs[0].imm);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
